dc_ipu_filter_phase_ctrl: RTL and testbench
===========================================

# dc_ipu_filter_phase_ctrl

Per-line phase sequencer for the IPU bicubic scaler. It walks a fixed-point source coordinate across one output line and feeds the fractional part (`alpha`) into the cubic-weights pipeline. It drives that pipeline's shared enable and tracks its 2-stage latency with valid bits. Each output carries the source index aligned with the weights, so the downstream tap multiplier and line buffer see a single valid/ready stream.

## Interface
Parameters:
- `WEIGHT_WIDTH`, 12: signed width of `alpha` and the weights; must be ≥ `WEIGHT_FRACT_WIDTH`+3.
- `WEIGHT_FRACT_WIDTH`, 8: fractional bits of phase, step and weights.
- `IDX_WIDTH`, 12: integer bits of the source coordinate.
- `LEN_WIDTH`, 12: width of line-length counters.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: line-start pulse; ignored while `busy`.
- `cfg_init_phase`, in, `IDX_WIDTH+WEIGHT_FRACT_WIDTH`: start coordinate, unsigned fixed point.
- `cfg_step`, in, `IDX_WIDTH+WEIGHT_FRACT_WIDTH`: source step per output pixel, unsigned fixed point.
- `cfg_out_len`, in, `LEN_WIDTH`: number of output pixels in the line.
- `cfg_src_len`, in, `LEN_WIDTH`: number of source pixels; used only with the clamp feature.
- `wgt_en`, out, 1: enable to the weights pipeline.
- `wgt_alpha`, out, `WEIGHT_WIDTH`: alpha to the weights pipeline.
- `out_valid`, out, 1: weights output and `out_src_idx` are valid.
- `out_ready`, in, 1: downstream accepts the current output.
- `out_src_idx`, out, `IDX_WIDTH`: integer source index aligned with the weights.
- `out_last`, out, 1: marks the final pixel of the line.
- `busy`, out, 1: high from `start` acceptance until `done`.
- `done`, out, 1: one-cycle pulse at end of line.

## Operation
- All config inputs are sampled on accepted `start`.
- `adv = !(out_valid && !out_ready)`.
- `wgt_en = adv` in every state; idle bubbles flow through the pipeline.
- FSM states:
  - IDLE → RUN on `start` when `cfg_out_len != 0`.
  - IDLE → DONE on `start` when `cfg_out_len == 0`; no outputs are produced.
  - RUN issues one pixel per cycle when `adv`.
  - RUN → DRAIN after the issue with `cnt == cfg_out_len-1`.
  - DRAIN → DONE when both valid bits are clear, or on the cycle the last output is accepted.
  - DONE → IDLE next cycle; `done=1` in the DONE cycle.
- Issue action:
  - `wgt_alpha = {0, acc[WEIGHT_FRACT_WIDTH-1:0]}`, so alpha is in [0, 1.0).
  - `idx = acc[MSBs]`.
  - `acc += cfg_step`, modulo `2^(IDX_WIDTH+WEIGHT_FRACT_WIDTH)` (wraps silently).
  - `cnt++`.
- Outside issue cycles, `wgt_alpha` holds its last value.
- Pipeline tracking:
  - `v0` and `v1` valid bits, plus idx and last sidecars, advance only when `adv`.
  - `v0 ← issue`, `v1 ← v0`.
  - `out_valid = v1`.
- `busy = (state != IDLE)`.
- `start` while busy is ignored, with no effect on the current line.

## Timing
- `start` accepted in cycle T; the first issue is in T+1 if `adv`.
- `out_valid` rises 2 advancing cycles after the issue, i.e. T+3 with no stall.
- Throughput is 1 pixel/cycle while `out_ready=1`.
- Stall: with `out_valid && !out_ready`, the following are all frozen:
  - `wgt_en=0`
  - acc, cnt, `v0`/`v1` and sidecars
  - `out_*`
- `done` occurs 1 cycle after the handshake of `out_last`.
- Reset values:
  - state=IDLE; acc, cnt, `v0`, `v1`, sidecars = 0.
  - `wgt_en=1`, `wgt_alpha=0`.
  - `out_valid=0`, `out_src_idx=0`, `out_last=0`, `busy=0`, `done=0`.
- Reset mid-line aborts immediately: there is no `done` and pending outputs are discarded.

## Configuration
- Macro: `DC_IPU_PHASE_CTRL_CLAMP_EN`.
- Defined: each issued `idx` saturates to `cfg_src_len-1` when larger, and `cfg_src_len==0` clamps to 0. `wgt_alpha` is forced to 0 for clamped pixels, giving pure edge replication.
- Undefined: `cfg_src_len` is ignored and `idx` is passed unmodified.

## Test plan
- Upscale with `init=0x000`, `step=0x180`, `out_len=4`, `out_ready=1`. Required response:
  - `start` at T0; outputs at T3..T6.
  - idx sequence 0,1,3,4; alpha 0x00,0x80,0x00,0x80.
  - `out_last` only at T6; `done` at T7.
  - Weights for alpha 0x80 are −0x10, 0x90, 0x90, −0x10.
- Backpressure: same line with `out_ready=0` at T3..T5. Required response:
  - `out_valid` held with idx 0 unchanged; `wgt_en=0`.
  - No pixel is lost or duplicated; idx order is still 0,1,3,4.
- `out_len=0`: `start` → no `out_valid`, `done` pulses at T1, `busy` high for 1 cycle.
- `start` pulsed again at T2 during a 4-pixel line → ignored; exactly 4 outputs and one `done`.
- Reset asserted at T4 of a line → next cycle all outputs equal their reset values, `busy=0`, and no `done`.
- With the clamp macro, `init=0x300`, `step=0x100`, `src_len=4`, `out_len=3`:
  - idx 3,3,3; alpha 0,0,0.
  - Without the macro: idx 3,4,5.

Source files
------------

// File: rtl/dc_ipu_filter_phase_ctrl.sv
// dc_ipu_filter_phase_ctrl
//
// This block sequences the filter phase for one output line of the IPU bicubic scaler.
// It steps a fixed-point source coordinate once per output pixel.
// The fractional part goes out as the weights-pipeline alpha.
// The integer source index and a last-pixel flag travel in sidecar registers.
// Those sidecars track the 2-stage latency of the weights pipeline.
// A stall on the output freezes the whole pipe, including the shared weights enable.
//
// Optional feature: define DC_IPU_PHASE_CTRL_CLAMP_EN to enable edge clamping.
// When it is defined, any source index beyond cfg_src_len-1 saturates to the last
// source pixel, and its alpha is forced to zero.
module dc_ipu_filter_phase_ctrl #(
    parameter int WEIGHT_WIDTH       = 12,
    parameter int WEIGHT_FRACT_WIDTH = 8,
    parameter int IDX_WIDTH          = 12,
    parameter int LEN_WIDTH          = 12
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [IDX_WIDTH+WEIGHT_FRACT_WIDTH-1:0] cfg_init_phase,
    input  logic [IDX_WIDTH+WEIGHT_FRACT_WIDTH-1:0] cfg_step,
    input  logic [LEN_WIDTH-1:0]                  cfg_out_len,
    input  logic [LEN_WIDTH-1:0]                  cfg_src_len,
    output logic                                  wgt_en,
    output logic [WEIGHT_WIDTH-1:0]               wgt_alpha,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [IDX_WIDTH-1:0]                  out_src_idx,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
);

    localparam int PHASE_WIDTH = IDX_WIDTH + WEIGHT_FRACT_WIDTH;
    localparam int CMP_WIDTH   = IDX_WIDTH + LEN_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [PHASE_WIDTH-1:0]        acc;
    logic [PHASE_WIDTH-1:0]        step_q;
    logic [LEN_WIDTH-1:0]          out_len_q;
    logic [LEN_WIDTH-1:0]          cnt;
    logic                          v0;
    logic                          v1;
    logic                          last0;
    logic                          last1;
    logic [IDX_WIDTH-1:0]          idx0;
    logic [IDX_WIDTH-1:0]          idx1;
    logic [WEIGHT_WIDTH-1:0]       alpha_q;

    logic                          adv;
    logic                          issue;
    logic                          last_issue;
    logic                          start_ok;
    logic [IDX_WIDTH-1:0]          raw_idx;
    logic [WEIGHT_FRACT_WIDTH-1:0] raw_frac;
    logic [IDX_WIDTH-1:0]          issue_idx;
    logic                          clamped;
    logic [WEIGHT_WIDTH-1:0]       issue_alpha;

    // The pipe advances unless a valid output is being held back by the consumer.
    assign adv        = !(v1 && !out_ready);
    assign issue      = (state == RUN) && adv;
    assign last_issue = (cnt == out_len_q - LEN_WIDTH'(1));
    assign raw_idx    = acc[PHASE_WIDTH-1:WEIGHT_FRACT_WIDTH];
    assign raw_frac   = acc[WEIGHT_FRACT_WIDTH-1:0];

`ifdef DC_IPU_PHASE_CTRL_CLAMP_EN
    logic [LEN_WIDTH-1:0] src_len_q;
    logic [LEN_WIDTH-1:0] src_lim;

    assign src_lim = src_len_q - LEN_WIDTH'(1);

    // Saturate the index at the last source pixel.
    // A zero-length source pins the index at 0.
    always_comb begin
        issue_idx = raw_idx;
        clamped   = 1'b0;
        if (src_len_q == '0) begin
            issue_idx = '0;
            clamped   = 1'b1;
        end else if (CMP_WIDTH'(raw_idx) > CMP_WIDTH'(src_lim)) begin
            issue_idx = IDX_WIDTH'(src_lim);
            clamped   = 1'b1;
        end
    end

    // Capture the source length together with the rest of the line configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_len_q <= '0;
        end else if (start_ok) begin
            src_len_q <= cfg_src_len;
        end
    end
`else
    logic unused_src_len;

    assign unused_src_len = ^cfg_src_len;
    assign issue_idx      = raw_idx;
    assign clamped        = 1'b0;
`endif

    // Clamped pixels replicate the edge, so they take zero alpha.
    assign issue_alpha = clamped ? '0
                                 : {{(WEIGHT_WIDTH-WEIGHT_FRACT_WIDTH){1'b0}}, raw_frac};

    assign wgt_en      = adv;
    assign wgt_alpha   = issue ? issue_alpha : alpha_q;
    assign out_valid   = v1;
    assign out_src_idx = idx1;
    assign out_last    = last1;

    // State register; a reset mid-line drops straight back to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, plus the busy, done and start-acceptance decodes.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        start_ok   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (cfg_out_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((!v0 && !v1) || (v1 && last1 && out_ready)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Phase accumulator and pixel counter.
    // Both load on an accepted start and step only on issue cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            step_q    <= '0;
            out_len_q <= '0;
            cnt       <= '0;
        end else if (start_ok) begin
            acc       <= cfg_init_phase;
            step_q    <= cfg_step;
            out_len_q <= cfg_out_len;
            cnt       <= '0;
        end else if (issue) begin
            acc <= acc + step_q;
            cnt <= cnt + LEN_WIDTH'(1);
        end
    end

    // Hold the most recently issued alpha between issue cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            alpha_q <= '0;
        end else if (issue) begin
            alpha_q <= issue_alpha;
        end
    end

    // Valid bits and sidecars mirror the 2-stage weights pipeline.
    // They move only when the shared enable is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0    <= 1'b0;
            v1    <= 1'b0;
            idx0  <= '0;
            idx1  <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else if (adv) begin
            v0    <= issue;
            v1    <= v0;
            if (issue) begin
                idx0 <= issue_idx;
            end
            idx1  <= idx0;
            last0 <= issue && last_issue;
            last1 <= last0;
        end
    end

endmodule

// File: tb/tb_dc_ipu_filter_phase_ctrl.sv
// tb_dc_ipu_filter_phase_ctrl
//
// Directed bench for the bicubic phase sequencer.
// Most scenarios are cycle-by-cycle rows of inputs and expected outputs.
// A hand-written sequence covers a restart attempt mid-line under irregular backpressure.
module tb_dc_ipu_filter_phase_ctrl;

`ifdef DC_IPU_PHASE_CTRL_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] cfg_init_phase;
    logic [19:0] cfg_step;
    logic [11:0] cfg_out_len;
    logic [11:0] cfg_src_len;
    logic        wgt_en;
    logic [11:0] wgt_alpha;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_src_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    dc_ipu_filter_phase_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_init_phase (cfg_init_phase),
        .cfg_step       (cfg_step),
        .cfg_out_len    (cfg_out_len),
        .cfg_src_len    (cfg_src_len),
        .wgt_en         (wgt_en),
        .wgt_alpha      (wgt_alpha),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_src_idx    (out_src_idx),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          start;
        logic [19:0] init;
        logic [19:0] step;
        logic [11:0] out_len;
        logic [11:0] src_len;
        bit          ready;
        bit          chk;
        bit          en;
        logic [11:0] alpha;
        bit          valid;
        logic [11:0] idx;
        bit          last;
        bit          busy;
        bit          done;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [19:0] cur_init;
    logic [19:0] cur_step;
    logic [11:0] cur_out_len;
    logic [11:0] cur_src_len;

    task automatic addRow(input bit rst, input bit st, input bit rdy, input bit chk,
                          input bit en, input logic [11:0] a, input bit v,
                          input logic [11:0] idx, input bit last, input bit bsy,
                          input bit dn);
        vec_t r;
        r.rst     = rst;
        r.start   = st;
        r.init    = cur_init;
        r.step    = cur_step;
        r.out_len = cur_out_len;
        r.src_len = cur_src_len;
        r.ready   = rdy;
        r.chk     = chk;
        r.en      = en;
        r.alpha   = a;
        r.valid   = v;
        r.idx     = idx;
        r.last    = last;
        r.busy    = bsy;
        r.done    = dn;
        vecs.push_back(r);
    endtask

    task automatic setCfg(input logic [19:0] init, input logic [19:0] step,
                          input logic [11:0] olen, input logic [11:0] slen);
        cur_init    = init;
        cur_step    = step;
        cur_out_len = olen;
        cur_src_len = slen;
    endtask

    task automatic resetRow();
        addRow(1, 0, 1, 0, 0, 12'h0, 0, 12'h0, 0, 0, 0);
    endtask

    task automatic applyStimulus(input vec_t r);
        reset          = r.rst;
        start          = r.start;
        cfg_init_phase = r.init;
        cfg_step       = r.step;
        cfg_out_len    = r.out_len;
        cfg_src_len    = r.src_len;
        out_ready      = r.ready;
    endtask

    task automatic checkOutput(input int n, input vec_t r);
        checks++;
        if ({wgt_en, wgt_alpha, out_valid, out_src_idx, out_last, busy, done} !==
            {r.en, r.alpha, r.valid, r.idx, r.last, r.busy, r.done}) begin
            errors++;
            $display("[TB] FAIL row %0d: got en=%b alpha=%h valid=%b idx=%h last=%b busy=%b done=%b, expected en=%b alpha=%h valid=%b idx=%h last=%b busy=%b done=%b",
                     n, wgt_en, wgt_alpha, out_valid, out_src_idx, out_last, busy, done,
                     r.en, r.alpha, r.valid, r.idx, r.last, r.busy, r.done);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          hs;
        int          dn;
        logic [11:0] got[$];
        logic [11:0] exp_idx[4];

        reset          = 1'b1;
        start          = 1'b0;
        out_ready      = 1'b1;
        cfg_init_phase = '0;
        cfg_step       = '0;
        cfg_out_len    = '0;
        cfg_src_len    = '0;

        // Upscale line: idx 0,1,3,4 with alpha 0,0x80,0,0x80.
        // Row args: rst, start, ready, chk, en, alpha, valid, idx, last, busy, done.
        setCfg(20'h00000, 20'h00180, 12'd4, 12'd0);
        resetRow();
        addRow(0, 1, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 1, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, 12'h1, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, 12'h3, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, 12'h4, 1, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h4, 0, 1, 1);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h4, 0, 0, 0);

        // Same line, consumer stalls for three cycles while idx 0 is presented.
        resetRow();
        addRow(0, 1, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 0, 1, 0, 12'h080, 1, 12'h0, 0, 1, 0);
        addRow(0, 0, 0, 1, 0, 12'h080, 1, 12'h0, 0, 1, 0);
        addRow(0, 0, 0, 1, 0, 12'h080, 1, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 1, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, 12'h1, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, 12'h3, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, 12'h4, 1, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h4, 0, 1, 1);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h4, 0, 0, 0);

        // Zero-length line: only a done pulse, busy for exactly one cycle.
        setCfg(20'h00180, 20'h00180, 12'd0, 12'd0);
        resetRow();
        addRow(0, 1, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 1, 1);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);

        // Reset asserted at T4: the outputs in T4 are still live, then everything returns to reset values.
        setCfg(20'h00000, 20'h00180, 12'd4, 12'd0);
        resetRow();
        addRow(0, 1, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 1, 12'h0, 0, 1, 0);
        addRow(1, 0, 1, 1, 1, 12'h080, 1, 12'h1, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);

        // Edge case near the end of the source: with clamping, idx 3,3,3; without it, idx 3,4,5.
        setCfg(20'h00300, 20'h00100, 12'd3, 12'd4);
        resetRow();
        addRow(0, 1, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 1, 12'h3, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 1, CLAMP ? 12'h3 : 12'h4, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 1, CLAMP ? 12'h3 : 12'h5, 1, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, CLAMP ? 12'h3 : 12'h5, 0, 1, 1);
        addRow(0, 0, 1, 1, 1, 12'h000, 0, CLAMP ? 12'h3 : 12'h5, 0, 0, 0);

        // The accumulator wraps from idx 0xFFF back to idx 0.
        setCfg(20'hFFF80, 20'h00100, 12'd2, 12'hFFF);
        resetRow();
        addRow(0, 1, 1, 1, 1, 12'h000, 0, 12'h0, 0, 0, 0);
        addRow(0, 0, 1, 1, 1, CLAMP ? 12'h000 : 12'h080, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h0, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, CLAMP ? 12'hFFE : 12'hFFF, 0, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 1, 12'h000, 1, 1, 0);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h000, 0, 1, 1);
        addRow(0, 0, 1, 1, 1, 12'h080, 0, 12'h000, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                checkOutput(i, vecs[i]);
            end
            @(posedge clk);
            #1;
        end

        // Second start during a 4-pixel line, with irregular backpressure.
        $display("[TB] restart-while-busy sequence");
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        cfg_init_phase = 20'h00000;
        cfg_step       = 20'h00180;
        cfg_out_len    = 12'd4;
        cfg_src_len    = 12'd0;
        start          = 1'b1;
        hs             = 0;
        dn             = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) begin
                start = 1'b0;
            end
            if (c == 2) begin
                start          = 1'b1;
                cfg_init_phase = 20'h00500;
                cfg_out_len    = 12'd2;
            end
            if (c == 3) begin
                start = 1'b0;
            end
            out_ready = ((c % 3) != 1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                hs++;
                got.push_back(out_src_idx);
            end
            if (done) begin
                dn++;
            end
            @(posedge clk);
            #1;
        end
        exp_idx = '{12'h0, 12'h1, 12'h3, 12'h4};
        checkValue("restart output count", hs, 4);
        for (int i = 0; i < 4; i++) begin
            checkValue($sformatf("restart idx[%0d]", i),
                       (i < got.size()) ? int'(got[i]) : -1, int'(exp_idx[i]));
        end
        checkValue("restart done count", dn, 1);
        checkValue("restart busy at end", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
